// File: rtl/parity_word_checker_if.sv
// rtl/parity_word_checker_if.sv - codeword input and checked-word output handshake bundle
interface parity_word_checker_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] code_in;
  logic       odd_sel;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] data_out;
  logic       out_err;

  modport master (
    output in_valid, code_in, odd_sel, out_ready,
    input  in_ready, out_valid, data_out, out_err
  );

  modport slave (
    input  in_valid, code_in, odd_sel, out_ready,
    output in_ready, out_valid, data_out, out_err
  );
endinterface

// File: rtl/parity_word_checker.sv
// rtl/parity_word_checker.sv - parity check of 8-bit codewords into a small {err, data} FIFO
// Optional PARITY_CHK_DROP_EN: failing words are counted but never stored.
module parity_word_checker #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  parity_word_checker_if.slave bus,
  input  logic                 clr_stats,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 err_sticky
);
  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [7:0]       r_mem [DEPTH];
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_err_sticky;

  logic             w_full;
  logic             w_empty;
  logic             w_err;
  logic             w_push;
  logic             w_store;
  logic             w_pop;
  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_err   = ^bus.code_in ^ bus.odd_sel;

  // Reset is folded in so the upstream sees no acceptance while rst_n is low.
  assign bus.in_ready  = rst_n & ~w_full;
  assign bus.out_valid = ~w_empty;
  assign w_push        = bus.in_valid & bus.in_ready;
  assign w_pop         = bus.out_valid & bus.out_ready;
  assign bus.data_out  = w_empty ? 7'd0 : r_mem[r_rd_ptr][6:0];

`ifdef PARITY_CHK_DROP_EN
  assign w_store     = w_push & ~w_err;
  assign bus.out_err = 1'b0;
`else
  assign w_store     = w_push;
  assign bus.out_err = ~w_empty & r_mem[r_rd_ptr][7];
`endif

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_wr_ptr] <= {w_err, bus.code_in[7:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Clear takes effect before a same-cycle failure is counted.
  always_comb begin
    w_cnt_base = clr_stats ? '0 : r_err_cnt;
    w_cnt_nxt  = w_cnt_base;
    if (w_push && w_err && (w_cnt_base != '1)) begin
      w_cnt_nxt = w_cnt_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      r_err_cnt    <= w_cnt_nxt;
      r_err_sticky <= (r_err_sticky & ~clr_stats) | (w_push & w_err);
    end
  end

  assign err_cnt    = r_err_cnt;
  assign err_sticky = r_err_sticky;
endmodule

// File: tb/tb_parity_word_checker.sv
// tb/tb_parity_word_checker.sv - scoreboard bench for parity_word_checker (DEPTH=4, CNT_W=2)
module tb_parity_word_checker;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_stats;
  logic [1:0] err_cnt;
  logic       err_sticky;

  parity_word_checker_if bus ();

  parity_word_checker #(.DEPTH(4), .CNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .clr_stats  (clr_stats),
    .err_cnt    (err_cnt),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

`ifdef PARITY_CHK_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  typedef struct {
    logic [6:0] data;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  bit   lat_chk = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check_eq("spurious_out", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check_eq("data_out", bus.data_out, e.data);
        check_eq("out_err", bus.out_err, e.err);
        if (lat_chk) check_eq("latency", cyc - e.cyc, 1);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send(input logic [7:0] code, input logic odd, output int waits);
    logic err;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.code_in  = code;
    bus.odd_sel  = odd;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready) break;
      waits++;
      if (waits >= 50) begin
        check_eq("accept_timeout", bus.in_ready, 1);
        bus.in_valid = 1'b0;
        return;
      end
    end
    err = (^code) ^ odd;
    if (!(DROP && err)) sb.push_back('{code[7:1], err, cyc});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
  endtask

  function automatic logic [7:0] mk(input logic [6:0] d, input logic odd, input logic bad);
    return {d, (^d) ^ odd ^ bad};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         w;
    logic [7:0] v;
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    rst_n         = 1'b0;
    clr_stats     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.code_in   = 8'h00;
    bus.odd_sel   = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_in_ready", bus.in_ready, 0);
    check_eq("rst_data_out", bus.data_out, 0);
    check_eq("rst_out_err", bus.out_err, 0);
    check_eq("rst_err_cnt", err_cnt, 0);
    check_eq("rst_sticky", err_sticky, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("idle_in_ready", bus.in_ready, 1);

    // Full sweep with correct parity, back to back.
    bus.out_ready = 1'b1;
    lat_chk = 1'b1;
    for (int i = 0; i < 256; i++) begin
      v = i[7:0];
      send(mk(v[7:1], v[0], 1'b0), v[0], w);
      check_eq("sweep_wait", w, 0);
    end
    drain("sweep_drain");
    lat_chk = 1'b0;
    check_eq("sweep_err_cnt", err_cnt, 0);
    check_eq("sweep_sticky", err_sticky, 0);

    // Same word judged under both parity senses.
    send(8'b0000_0011, 1'b1, w);
    drain("bad1_drain");
    check_eq("bad1_err_cnt", err_cnt, 1);
    check_eq("bad1_sticky", err_sticky, 1);
    send(8'b0000_0011, 1'b0, w);
    drain("good1_drain");
    check_eq("good1_err_cnt", err_cnt, 1);

    // Backpressure: fill, hold off the 5th, release.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(mk(7'h10 + 7'(i), i[0], 1'b0), i[0], w);
      check_eq("fill_wait", w, 0);
    end
    @(negedge clk);
    check_eq("full_in_ready", bus.in_ready, 0);
    check_eq("full_out_valid", bus.out_valid, 1);
    bus.in_valid = 1'b1;
    bus.code_in  = mk(7'h55, 1'b0, 1'b0);
    bus.odd_sel  = 1'b0;
    @(negedge clk);
    check_eq("held_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("pop_cycle_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    send(mk(7'h55, 1'b0, 1'b0), 1'b0, w);
    check_eq("ready_after_pop", w, 0);
    drain("bp_drain");

    // Saturation and clear priority.
    pulse_clr();
    check_eq("clr_err_cnt", err_cnt, 0);
    check_eq("clr_sticky", err_sticky, 0);
    for (int k = 0; k < 5; k++) begin
      send(mk(7'h20 + 7'(k), k[0], 1'b1), k[0], w);
      check_eq("sat_err_cnt", err_cnt, exp_cnt[k]);
      check_eq("sat_sticky", err_sticky, 1);
    end
    clr_stats = 1'b1;
    send(mk(7'h33, 1'b0, 1'b1), 1'b0, w);
    clr_stats = 1'b0;
    check_eq("clr_bad_err_cnt", err_cnt, 1);
    check_eq("clr_bad_sticky", err_sticky, 1);
    drain("sat_drain");

    // Asynchronous reset with words buffered.
    bus.out_ready = 1'b0;
    send(mk(7'h01, 1'b0, 1'b0), 1'b0, w);
    send(mk(7'h02, 1'b1, 1'b0), 1'b1, w);
    send(mk(7'h03, 1'b0, 1'b1), 1'b0, w);
    check_eq("pre_rst_err_cnt", err_cnt, 2);
    check_eq("pre_rst_out_valid", bus.out_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", bus.out_valid, 0);
    check_eq("mid_rst_err_cnt", err_cnt, 0);
    check_eq("mid_rst_sticky", err_sticky, 0);
    check_eq("mid_rst_in_ready", bus.in_ready, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("post_rst_out_valid", bus.out_valid, 0);
    check_eq("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Good, bad, good with the consumer always ready.
    bus.out_ready = 1'b1;
    send(mk(7'h4A, 1'b0, 1'b0), 1'b0, w);
    check_eq("mix_wait0", w, 0);
    send(mk(7'h4B, 1'b1, 1'b1), 1'b1, w);
    check_eq("mix_wait1", w, 0);
    send(mk(7'h4C, 1'b1, 1'b0), 1'b1, w);
    check_eq("mix_wait2", w, 0);
    drain("mix_drain");
    check_eq("mix_err_cnt", err_cnt, 1);
    check_eq("mix_in_ready", bus.in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
